// File: rtl/router_src_arbiter.sv
// Round-robin arbiter sharing the 1x3 router's single byte-wide input among NSRC
// packet sources; packets addressed to the reserved port 3 are swallowed here.
module router_src_arbiter #(
    parameter int NSRC    = 3,
    parameter int MIN_GAP = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NSRC-1:0]   src_valid,
    input  logic [8*NSRC-1:0] src_data,
    output logic [NSRC-1:0]   src_ready,
    input  logic              busy,
    output logic [7:0]        rtr_data,
    output logic              rtr_pkt_valid,
    output logic [NSRC-1:0]   grant,
    output logic              drop_err,
    output logic              underrun_err
);
    localparam int            IW       = $clog2(NSRC);
    localparam logic [IW-1:0] LAST_IDX = IW'(NSRC - 1);
    localparam logic [3:0]    GAP_LAST = 4'(MIN_GAP - 1);

    typedef enum logic [2:0] {IDLE, PAYLOAD, PARITY, GAP, DROP} state_t;

    state_t        state;
    logic [6:0]    count;
    logic [3:0]    gap_count;
    logic [IW-1:0] owner;
    logic [IW-1:0] last_grant;
    logic [IW-1:0] winner;
    logic          found;
    logic [7:0]    lane [NSRC];
    logic [7:0]    head;
    logic [7:0]    owner_byte;
    logic          owner_valid;

    for (genvar i = 0; i < NSRC; i++) begin : g_lane
        assign lane[i] = src_data[8*i +: 8];
    end

    assign head        = lane[winner];
    assign owner_byte  = lane[owner];
    assign owner_valid = src_valid[owner];

    // Search starts one past the previous owner so every source gets a turn.
    always_comb begin
        int            idx;
        logic [IW-1:0] cand;
        winner = last_grant;
        found  = 1'b0;
        for (int off = 1; off <= NSRC; off++) begin
            idx = int'(last_grant) + off;
            if (idx >= NSRC) idx = idx - NSRC;
            cand = IW'(idx);
            if (!found && src_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        src_ready = '0;
        if (!reset) begin
            case (state)
                IDLE:            if (!busy && found) src_ready[winner] = 1'b1;
                PAYLOAD, PARITY: if (!busy) src_ready[owner] = 1'b1;
                DROP:            src_ready[owner] = owner_valid;
                default:         src_ready = '0;
            endcase
        end
    end

    // A slot whose source is not valid still counts, so the packet length seen
    // by the router never depends on upstream hiccups.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            count         <= '0;
            gap_count     <= '0;
            owner         <= '0;
            last_grant    <= LAST_IDX;
            rtr_data      <= '0;
            rtr_pkt_valid <= 1'b0;
            grant         <= '0;
            drop_err      <= 1'b0;
            underrun_err  <= 1'b0;
        end else begin
            drop_err     <= 1'b0;
            underrun_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!busy && found) begin
                        owner <= winner;
                        grant <= NSRC'(1) << winner;
                        if (head[1:0] != 2'b11) begin
                            rtr_data      <= head;
                            rtr_pkt_valid <= 1'b1;
                            count         <= {1'b0, head[7:2]};
                            state         <= (head[7:2] != 6'd0) ? PAYLOAD : PARITY;
                        end else begin
                            drop_err <= 1'b1;
                            count    <= {1'b0, head[7:2]} + 7'd1;
                            state    <= DROP;
                        end
                    end
                end
                PAYLOAD: begin
                    if (!busy) begin
                        rtr_data      <= owner_valid ? owner_byte : 8'h00;
                        rtr_pkt_valid <= 1'b1;
                        underrun_err  <= !owner_valid;
                        count         <= count - 7'd1;
                        if (count == 7'd1) state <= PARITY;
                    end
                end
                PARITY: begin
                    if (!busy) begin
                        rtr_data      <= owner_valid ? owner_byte : 8'h00;
                        rtr_pkt_valid <= 1'b0;
                        underrun_err  <= !owner_valid;
                        gap_count     <= '0;
                        state         <= GAP;
                    end
                end
                GAP: begin
                    rtr_data      <= '0;
                    rtr_pkt_valid <= 1'b0;
                    grant         <= '0;
                    last_grant    <= owner;
                    if (gap_count == GAP_LAST) state <= IDLE;
                    else gap_count <= gap_count + 4'd1;
                end
                DROP: begin
                    if (owner_valid) begin
                        count <= count - 7'd1;
                        if (count == 7'd1) begin
                            grant      <= '0;
                            last_grant <= owner;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_router_src_arbiter.sv
// Bench for router_src_arbiter: per-source byte queues drive the DUT, and a
// packet-level round-robin scoreboard predicts every consumed and forwarded byte.
module tb_router_src_arbiter;
    localparam int NSRC   = 3;
    localparam int BUDGET = 4000;

    typedef struct {
        int         src;
        logic [7:0] data;
        int         pos;
        bit         drop;
        bit         parity;
    } exp_t;

    logic              clock = 1'b0;
    logic              reset;
    logic [NSRC-1:0]   src_valid;
    logic [8*NSRC-1:0] src_data;
    logic [NSRC-1:0]   src_ready;
    logic              busy;
    logic [7:0]        rtr_data;
    logic              rtr_pkt_valid;
    logic [NSRC-1:0]   grant;
    logic              drop_err;
    logic              underrun_err;

    always #5 clock = ~clock;

    router_src_arbiter #(.NSRC(NSRC), .MIN_GAP(1)) dut (
        .clock        (clock),
        .reset        (reset),
        .src_valid    (src_valid),
        .src_data     (src_data),
        .src_ready    (src_ready),
        .busy         (busy),
        .rtr_data     (rtr_data),
        .rtr_pkt_valid(rtr_pkt_valid),
        .grant        (grant),
        .drop_err     (drop_err),
        .underrun_err (underrun_err)
    );

    int              n_cmp = 0;
    int              n_fail = 0;
    logic [7:0]      sq    [NSRC][$];
    logic [7:0]      stage [NSRC][$];
    exp_t            exp_q [$];
    logic [NSRC-1:0] grant_log [$];
    int              model_last;
    int              tick_count;
    int              busy_lo;
    int              busy_hi;
    int              drop_pulses;
    int              under_pulses;
    int              under_src;
    int              under_pos;
    bit              busy_rand;
    bit              under_armed;
    bit              gap_next;
    logic [7:0]      last_data;
    logic [NSRC-1:0] rr_exp [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, want);
        end
    endtask

    function automatic logic [NSRC-1:0] onehot(input int s);
        return NSRC'(1) << s;
    endfunction

    function automatic void drive_sources();
        bit masked;
        for (int i = 0; i < NSRC; i++) begin
            masked = under_armed && i == under_src && exp_q.size() > 0 &&
                     exp_q[0].src == i && exp_q[0].pos == under_pos;
            src_valid[i]      = sq[i].size() > 0 && !masked;
            src_data[8*i +: 8] = (sq[i].size() > 0) ? sq[i][0] : 8'h00;
        end
    endfunction

    // Header, len payload bytes, then the XOR parity of everything before it.
    task automatic add_packet(input int s, input int len, input logic [1:0] addr);
        logic [7:0] b;
        logic [7:0] par;
        b   = {6'(len), addr};
        par = b;
        sq[s].push_back(b);
        stage[s].push_back(b);
        for (int k = 0; k < len; k++) begin
            b   = 8'($urandom);
            par = par ^ b;
            sq[s].push_back(b);
            stage[s].push_back(b);
        end
        sq[s].push_back(par);
        stage[s].push_back(par);
    endtask

    // Whole packets are served in turn, starting after the previous owner.
    task automatic build_order();
        int         s;
        int         len;
        bit         any;
        logic [7:0] h;
        exp_t       e;
        any = 1'b1;
        s   = 0;
        while (any) begin
            any = 1'b0;
            for (int off = 1; off <= NSRC && !any; off++) begin
                s = (model_last + off) % NSRC;
                if (stage[s].size() > 0) any = 1'b1;
            end
            if (any) begin
                h   = stage[s].pop_front();
                len = int'(h[7:2]);
                for (int p = 0; p <= len + 1; p++) begin
                    e.src    = s;
                    e.data   = (p == 0) ? h : stage[s].pop_front();
                    e.pos    = p;
                    e.drop   = (h[1:0] == 2'b11);
                    e.parity = (p == len + 1);
                    exp_q.push_back(e);
                end
                model_last = s;
            end
        end
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        busy        = 1'b0;
        under_armed = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            sq[i].delete();
            stage[i].delete();
        end
        exp_q.delete();
        grant_log.delete();
        drive_sources();
        @(posedge clock);
        #1;
        check("reset_rtr_data", rtr_data, 0);
        check("reset_pkt_valid", rtr_pkt_valid, 0);
        check("reset_grant", grant, 0);
        check("reset_drop_err", drop_err, 0);
        check("reset_underrun_err", underrun_err, 0);
        check("reset_src_ready", src_ready, 0);
        @(negedge clock);
        reset      = 1'b0;
        model_last = NSRC - 1;
        gap_next   = 1'b0;
        tick_count = 0;
        busy_rand  = 1'b0;
        busy_lo    = 0;
        busy_hi    = -1;
    endtask

    // One clock: drive at the falling edge, check handshake, then check outputs after the rising edge.
    task automatic tick();
        logic [NSRC-1:0] ready_snap;
        logic [NSRC-1:0] valid_snap;
        logic [NSRC-1:0] want_ready;
        bit              busy_snap;
        bit              took;
        exp_t            e;
        tick_count++;
        if (busy_rand) busy = ($urandom_range(0, 3) == 0);
        else busy = (tick_count >= busy_lo && tick_count <= busy_hi);
        drive_sources();
        #1;
        ready_snap = src_ready;
        valid_snap = src_valid;
        busy_snap  = busy;
        took       = 1'b0;
        e          = '{src: 0, data: 8'h00, pos: 0, drop: 1'b0, parity: 1'b0};
        if (gap_next) check("gap_ready", ready_snap, 0);
        if (exp_q.size() > 0) begin
            e = exp_q[0];
            if (e.pos > 0 && e.drop) check("drop_ready", ready_snap, onehot(e.src));
            else if (e.pos > 0) begin
                want_ready = busy_snap ? '0 : onehot(e.src);
                check("fwd_ready", ready_snap, want_ready);
            end
            else if (busy_snap) check("idle_busy_ready", ready_snap, 0);
            else if (ready_snap != '0) check("arb_owner", ready_snap, onehot(e.src));
            took = ready_snap[e.src];
        end else begin
            check("no_work_ready", ready_snap, 0);
        end
        for (int i = 0; i < NSRC; i++)
            if (ready_snap[i] && valid_snap[i]) void'(sq[i].pop_front());
        if (took) begin
            void'(exp_q.pop_front());
            if (!valid_snap[e.src]) begin
                if (sq[e.src].size() > 0) void'(sq[e.src].pop_front());
                under_armed = 1'b0;
            end
        end
        @(posedge clock);
        #1;
        if (took) begin
            if (e.pos == 0) grant_log.push_back(grant);
            if (e.drop) begin
                check("drop_err", drop_err, e.pos == 0);
                check("drop_pkt_valid", rtr_pkt_valid, 0);
                check("drop_data", rtr_data, 0);
                if (e.pos == 0) check("drop_grant", grant, onehot(e.src));
            end else begin
                last_data = valid_snap[e.src] ? e.data : 8'h00;
                check("data", rtr_data, last_data);
                check("pkt_valid", rtr_pkt_valid, !e.parity);
                check("grant", grant, onehot(e.src));
                check("underrun_err", underrun_err, !valid_snap[e.src]);
                check("drop_err_fwd", drop_err, 0);
                gap_next = e.parity;
            end
        end else if (gap_next) begin
            check("gap_data", rtr_data, 0);
            check("gap_pkt_valid", rtr_pkt_valid, 0);
            check("gap_grant", grant, 0);
            gap_next = 1'b0;
        end else if (exp_q.size() > 0 && exp_q[0].pos > 0 && !exp_q[0].drop) begin
            check("hold_data", rtr_data, last_data);
            check("hold_pkt_valid", rtr_pkt_valid, 1);
            check("hold_underrun", underrun_err, 0);
        end else begin
            check("idle_pkt_valid", rtr_pkt_valid, 0);
        end
        if (drop_err) drop_pulses++;
        if (underrun_err) under_pulses++;
        @(negedge clock);
    endtask

    task automatic run_until_done(input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        check("all_consumed", exp_q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};

        // Single source, L=10, no busy: 12 back-to-back bytes then one idle cycle.
        do_reset();
        add_packet(0, 10, 2'b00);
        build_order();
        run_until_done(100);
        check("single_ticks", tick_count, 12);
        if (grant_log.size() > 0) check("single_grant", grant_log[0], 3'b001);
        tick();

        // Round robin with all three sources contending.
        do_reset();
        add_packet(0, 2, 2'b00);
        add_packet(1, 2, 2'b01);
        add_packet(2, 2, 2'b10);
        add_packet(0, 2, 2'b01);
        build_order();
        run_until_done(200);
        check("rr_count", grant_log.size(), 4);
        for (int k = 0; k < 4; k++)
            if (k < grant_log.size()) check($sformatf("rr_grant_%0d", k), grant_log[k], rr_exp[k]);

        // Busy for four cycles after the third payload byte of an L=16 packet.
        do_reset();
        busy_lo = 5;
        busy_hi = 8;
        add_packet(0, 16, 2'b01);
        build_order();
        run_until_done(200);
        check("stall_ticks", tick_count, 22);

        // Reserved address: packet swallowed, next turn goes to src2.
        do_reset();
        drop_pulses = 0;
        add_packet(1, 2, 2'b11);
        add_packet(2, 1, 2'b00);
        build_order();
        run_until_done(200);
        check("drop_pulses", drop_pulses, 1);
        check("drop_grant_count", grant_log.size(), 2);
        if (grant_log.size() > 1) begin
            check("drop_first_grant", grant_log[0], 3'b010);
            check("drop_next_grant", grant_log[1], 3'b100);
        end

        // Underrun on the second payload byte of an L=4 packet.
        do_reset();
        under_pulses = 0;
        under_armed  = 1'b1;
        under_src    = 0;
        under_pos    = 2;
        add_packet(0, 4, 2'b10);
        build_order();
        run_until_done(100);
        check("under_pulses", under_pulses, 1);
        check("under_ticks", tick_count, 6);
        tick();

        // Reset in the middle of payload byte 5 after src0 last owned the port.
        do_reset();
        add_packet(0, 1, 2'b00);
        build_order();
        run_until_done(100);
        tick();
        add_packet(0, 8, 2'b01);
        build_order();
        for (int n = 0; n < 50 && exp_q.size() > 0 && exp_q[0].pos != 6; n++) tick();
        check("mid_reached", exp_q.size() > 0 && exp_q[0].pos == 6, 1);
        do_reset();
        add_packet(1, 1, 2'b00);
        add_packet(0, 1, 2'b00);
        build_order();
        run_until_done(100);
        if (grant_log.size() > 0) check("post_reset_first", grant_log[0], 3'b001);

        // Randomised traffic with random busy.
        do_reset();
        busy_rand = 1'b1;
        add_packet(2, 0, 2'b01);
        for (int s = 0; s < NSRC; s++)
            for (int p = $urandom_range(1, 4); p > 0; p--)
                add_packet(s, $urandom_range(0, 6), 2'($urandom_range(0, 3)));
        build_order();
        run_until_done(BUDGET);
        busy_rand = 1'b0;
        busy = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/router_src_arbiter.md
# router_src_arbiter

Round-robin packet arbiter that shares the single 8-bit input port of the 1x3 router among `NSRC` upstream packet sources. It grants one source per packet and forwards header, payload and parity bytes in the router's framing: `pkt_valid` is high for the header and payload and low for the parity byte. It holds the outputs while the router asserts `busy`. Packets with the reserved address 2'b11 are discarded at the input rather than forwarded.

## Interface
- `NSRC`, default 3 — number of upstream sources (2..8).
- `MIN_GAP`, default 1 — idle cycles driven between packets (1..15).
- `clock` in 1 — single clock; all logic on the rising edge.
- `reset` in 1 — synchronous, active-high.
- `src_valid` in NSRC — source i has a byte on its `src_data` lane.
- `src_data` in 8*NSRC — source i byte at bits [8i+7:8i].
- `src_ready` out NSRC — combinational; the byte on lane i is consumed this cycle.
- `busy` in 1 — router busy; stalls forwarding.
- `rtr_data` out 8 — registered byte to the router `data_in`.
- `rtr_pkt_valid` out 1 — registered; to the router `pkt_valid`.
- `grant` out NSRC — registered one-hot owner of the current packet; 0 when none.
- `drop_err` out 1 — one-cycle pulse when a packet with address 2'b11 is discarded.
- `underrun_err` out 1 — one-cycle pulse when the granted source is not valid during a forwarding slot.

## Operation
- Header format: bits [7:2] are the payload length L (0..63); bits [1:0] are the destination address. A packet is header, then L payload bytes, then one parity byte, all supplied by the source.
- A forwarding slot is any cycle with `busy`=0 in the PAYLOAD or PARITY state.
- FSM states: IDLE, PAYLOAD, PARITY, GAP, DROP.
- **IDLE**, with `busy`=0 and any `src_valid`:
  - Winner = first valid index after `last_grant`, wrapping modulo NSRC.
  - `src_ready[winner]`=1; the header is consumed.
  - If address != 3: `rtr_data`<=header, `rtr_pkt_valid`<=1, `grant`<=onehot(winner), counter<=L. Next state is PAYLOAD if L>0, else PARITY.
  - If address == 3: `drop_err` pulses, `grant`<=onehot(winner), counter<=L+1, next state DROP. Nothing is driven to the router.
- **PAYLOAD**, each forwarding slot:
  - `src_ready[g]`=1; `rtr_data`<=`src_data[g]`, `rtr_pkt_valid`<=1; counter decrements.
  - If `src_valid[g]`=0: 8'h00 is forwarded instead, the slot still counts, and `underrun_err` pulses.
  - When the counter reaches 0, next state is PARITY.
- **PARITY**, forwarding slot:
  - The byte is consumed as in PAYLOAD (8'h00 plus `underrun_err` if the source is not valid).
  - `rtr_pkt_valid`<=0 with the parity byte; next state GAP.
- **GAP**:
  - `rtr_data`<=0, `rtr_pkt_valid`<=0, `grant`<=0, `last_grant`<=g.
  - After MIN_GAP cycles, next state is IDLE.
- **DROP**:
  - `src_ready[g]`=`src_valid[g]`, regardless of `busy`; the counter decrements per consumed byte.
  - At 0: `grant`<=0, `last_grant`<=g, next state IDLE. Outputs to the router stay 0 throughout.
- When `busy`=1 in PAYLOAD or PARITY: `src_ready`=0, and `rtr_data`, `rtr_pkt_valid` and the counter hold. A busy cycle is not an underrun.
- When `busy`=1 in IDLE: no arbitration.
- Sources not granted always see `src_ready`=0.

## Timing
- Reset values: `rtr_data`=0, `rtr_pkt_valid`=0, `grant`=0, `src_ready`=0, both error outputs 0, state IDLE, counter 0, `last_grant`=NSRC-1 (source 0 has first priority).
- Latency: a byte consumed at edge N appears on `rtr_data` after edge N. The error pulses are registered and appear in the same cycle as the corresponding `rtr_data` update.
- A packet of length L occupies the router port for L+2 cycles with no busy, followed by MIN_GAP idle cycles.
- `busy` is sampled in the same cycle as `src_ready`. `busy` rising mid-packet freezes the output on the last forwarded byte.
- Reset asserted mid-packet: all state returns to reset values at the next edge. The partial packet is abandoned; no parity is emitted.
- Simultaneous requests with `last_grant`=k: priority order is k+1, k+2, …, wrapping, ending at k.

## Test plan
- **Single source:** src0 sends header 8'h28 (L=10, addr 0), 10 payload bytes and correct parity; `busy`=0. Expect 12 consecutive `rtr_data` bytes, `rtr_pkt_valid` high for 11 then low on parity, `grant`=3'b001, then 1 GAP cycle.
- **Round-robin:** all three sources request continuously with L=2. Expect the grant sequence 001, 010, 100, 001, and no source consumed out of turn.
- **Busy stall:** assert `busy` for 4 cycles after the 3rd payload byte of an L=16 packet. Expect `rtr_data` held, `src_ready`=0, and forwarding resumed without loss or duplication; total packet cycles = 18+4.
- **Address 3:** src1 sends header 8'h0B (L=2, addr 3) and 3 more bytes. Expect `drop_err` pulsed once, `rtr_pkt_valid`=0 throughout, all 4 bytes consumed, and the next grant going to src2 if it is requesting.
- **Underrun:** src0 drops `src_valid` for the 2nd payload byte of an L=4 packet. Expect 8'h00 forwarded in that slot, one `underrun_err` pulse, and the total length still L+2.
- **Reset mid-packet:** assert `reset` during payload byte 5. Expect all outputs 0 next cycle, and the next arbitration starting at src0.
